// File: rtl/alu_pkg.sv
// Shared encodings and helpers for the MOV/EQ/NE operand unit.
package alu_pkg;

    // Operation codes; OP_RSV executes as a move.
    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_EQ  = 2'b01,
        OP_NE  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // ceil(log2(n)), never less than 1 so a one-chunk counter still has a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/alu_eqmov_seq_if.sv
// Request/response bundle between the register-read stage and the operand unit.
interface alu_eqmov_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             eq;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, s, eq, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, s, eq, busy
    );
endinterface

// File: rtl/chunk_sel_eq.sv
// Picks chunk idx out of both operands and reports whether the slices match.
module chunk_sel_eq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CHUNK  = 8,
    localparam int unsigned NCHUNK = WIDTH / CHUNK,
    localparam int unsigned IDXW   = clog2_min1(NCHUNK)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [IDXW-1:0]  idx,
    output logic             match
);
    // Padded to a power of two so idx selects without a width mismatch.
    logic [(2**IDXW)-1:0] hit;

    for (genvar i = 0; i < 2**IDXW; i++) begin : g_chunk
        if (i < NCHUNK) begin : g_real
            assign hit[i] = (a[i*CHUNK +: CHUNK] == b[i*CHUNK +: CHUNK]);
        end else begin : g_pad
            assign hit[i] = 1'b0;
        end
    end

    assign match = hit[idx];
endmodule

// File: rtl/alu_eqmov_seq.sv
// Operand unit: registered move of A, or chunked multi-cycle EQ/NE with early exit.
module alu_eqmov_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic            clk,
    input logic            rst,
    alu_eqmov_seq_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = clog2_min1(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    op_e              op_q, op_d;
    logic             eq_q, eq_d;
    logic             match;
    logic             in_ready;

    chunk_sel_eq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) u_chunk_sel_eq (
        .a     (a_q),
        .b     (b_q),
        .idx   (idx_q),
        .match (match)
    );

    assign in_ready      = (state_q == ST_IDLE) && !rst;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.s         = s_q;
    assign bus.eq        = eq_q;

    // Next-state: capture on accept, walk chunks LSB first, hold result until taken.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        s_d     = s_q;
        eq_d    = eq_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready) begin
                    a_d  = bus.a;
                    b_d  = bus.b;
                    op_d = bus.op;
                    if (bus.op == OP_EQ || bus.op == OP_NE) begin
                        idx_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        s_d     = bus.a;
                        eq_d    = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (!match || idx_q == LAST_IDX) begin
                    eq_d    = match;
                    s_d     = '0;
                    s_d[0]  = (op_q == OP_NE) ? ~match : match;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_MOV;
            s_q     <= '0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            s_q     <= s_d;
            eq_q    <= eq_d;
        end
    end
endmodule
